output_spike_classifier: RTL and testbench
==========================================

# output_spike_classifier

Downstream stage of the two-layer delayed-SNN core. Consumes the core's 8-bit `output_spikes` vector each time `output_data_ready` pulses. Over a programmable window of such samples it keeps one saturating spike counter per output neuron. At the end of the window it runs a sequential argmax and presents the winning class index on a valid/ready handshake.

## Interface
- `N_OUT`, 8, number of output neurons (width of the spike vector)
- `CNT_W`, 6, bits per spike counter (saturating)
- `WIN_W`, 8, bits of the window-length field
- `IDX_W`, `$clog2(N_OUT)` (3), bits of the class index
- `clk`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `enable`  in  1  gates accumulation; low means `spikes_valid` is ignored and the window is frozen
- `window_len`  in  WIN_W  samples per classification window; latched at window start; 0 is treated as 1
- `spikes_in`  in  N_OUT  output spike vector from the SNN core
- `spikes_valid`  in  1  one-cycle qualifier for `spikes_in` (core's `output_data_ready`)
- `class_out`  out  IDX_W  winning neuron index
- `class_valid`  out  1  `class_out` / `no_spike` valid
- `class_ready`  in  1  consumer accepts the result
- `no_spike`  out  1  all counters were zero in the window (`class_out` = 0)
- `counts_out`  out  N_OUT*CNT_W  live counters; neuron i at `[i*CNT_W +: CNT_W]`
- `overrun`  out  1  sticky: a `spikes_valid` arrived while not accumulating
- `busy`  out  1  high in ARGMAX and HOLD

## Operation
FSM states:
- **IDLE**
  - Entered on reset.
  - Moves to ACCUM on the first cycle `enable` = 1.
  - On that move: latch `window_len` (0 becomes 1), clear the sample counter.
- **ACCUM**
  - Each cycle with `enable` & `spikes_valid`:
    - for every i, counter[i] += `spikes_in[i]`, saturating at 2^CNT_W−1;
    - sample counter += 1.
  - When the sample counter reaches the latched length on that edge, move to ARGMAX with scan index 0 and best = (idx 0, count 0).
- **ARGMAX**
  - One neuron per cycle, index 0..N_OUT−1.
  - Replace best only if counter[idx] > best count (strict), so ties go to the lowest index.
  - After index N_OUT−1, register the result and move to HOLD.
  - `no_spike` = 1 if the best count is 0.
- **HOLD**
  - `class_valid` = 1; `class_out` and `no_spike` are stable.
  - On `class_valid` & `class_ready`:
    - clear all counters;
    - re-latch `window_len`, clear the sample counter;
    - go to ACCUM, or to IDLE if `enable` = 0.
- `spikes_valid` in IDLE, ARGMAX or HOLD:
  - the sample is dropped;
  - `overrun` is set and stays set until `reset`.
- `enable` low in ACCUM:
  - counters and sample counter hold;
  - the state stays ACCUM.
- ARGMAX and HOLD run regardless of `enable`.
- `counts_out` is frozen during ARGMAX and HOLD.

## Timing
- Reset values:
  - state IDLE;
  - all counters 0, sample counter 0;
  - `class_out` 0, `class_valid` 0, `no_spike` 0, `overrun` 0, `busy` 0.
- Reset mid-window or mid-HOLD: everything above is restored on the next edge; any pending result is discarded.
- Edge E0 samples the final `spikes_valid`:
  - counters include that sample after E0;
  - state = ARGMAX, `busy` = 1.
- Edges E1..E(N_OUT) scan indices 0..N_OUT−1.
  - `class_valid` rises after edge E(N_OUT), i.e. 8 cycles after the last sample at defaults.
- Handshake:
  - `class_valid` is held until accepted; the result is unchanged while waiting.
  - Accept edge: `class_valid` falls and counters read 0 after it.
  - A `spikes_valid` coincident with the accept edge is dropped and sets `overrun`.
- `class_ready` high with `class_valid` low has no effect.
- Saturation: a counter at 2^CNT_W−1 stays there; its neighbours keep counting.

## Structure
- Package `snn_cls_pkg`:
  - state enum (IDLE, ACCUM, ARGMAX, HOLD);
  - default `N_OUT`, `CNT_W`, `WIN_W` constants;
  - `sat_max` constant function.
- Sub-module `spike_sat_counter`:
  - one per neuron;
  - ports: `clk`, `reset`, `clear`, `inc`, `count[CNT_W]`;
  - saturating increment; `clear` has priority over `inc`.
- Top holds the FSM, sample counter, argmax scan registers and `overrun`.

## Test plan
- `window_len` = 4; four samples of 8'b0000_0100 with `class_ready` = 1:
  - `class_out` = 2, `no_spike` = 0;
  - `class_valid` rises 8 cycles after the 4th sample;
  - counters read 0 after accept.
- `window_len` = 3; samples 8'h81, 8'h80, 8'h01:
  - neurons 0 and 7 tie at 2;
  - `class_out` = 0.
- `window_len` = 70; neuron 5 spikes every sample, neuron 3 on 60 samples:
  - neuron 5 saturates at 63, neuron 3 reads 60;
  - `class_out` = 5.
- `window_len` = 0, one all-zero sample:
  - the window closes after 1 sample;
  - `no_spike` = 1, `class_out` = 0.
- Hold `class_ready` = 0 for 20 cycles in HOLD and pulse `spikes_valid` there:
  - `class_valid` stays high with a stable `class_out`;
  - `overrun` = 1;
  - counters are unchanged until accept.
- Assert `reset` two samples into a 4-sample window:
  - all outputs return to reset values;
  - the next window needs four fresh samples.

Source files
------------

// File: rtl/snn_cls_pkg.sv
// Shared types and constants for the output spike classifier.
package snn_cls_pkg;

   localparam int unsigned N_OUT_DEF = 8;
   localparam int unsigned CNT_W_DEF = 6;
   localparam int unsigned WIN_W_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCUM  = 2'd1,
      ST_ARGMAX = 2'd2,
      ST_HOLD   = 2'd3
   } state_t;

   // Largest value representable in a w-bit counter.
   function automatic int unsigned sat_max(input int unsigned w);
      return (32'd1 << w) - 32'd1;
   endfunction

endpackage

// File: rtl/output_spike_classifier_if.sv
// Spike sample input and classification result handshake.
interface output_spike_classifier_if
   import snn_cls_pkg::*;
#(
   parameter int unsigned N_OUT = N_OUT_DEF,
   parameter int unsigned IDX_W = $clog2(N_OUT_DEF)
);
   logic [N_OUT-1:0] spikes_in;
   logic             spikes_valid;
   logic [IDX_W-1:0] class_out;
   logic             class_valid;
   logic             class_ready;
   logic             no_spike;

   modport master (
      output spikes_in, spikes_valid, class_ready,
      input  class_out, class_valid, no_spike
   );

   modport slave (
      input  spikes_in, spikes_valid, class_ready,
      output class_out, class_valid, no_spike
   );
endinterface

// File: rtl/spike_sat_counter.sv
// Per-neuron saturating spike counter; clear wins over increment.
module spike_sat_counter
   import snn_cls_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(sat_max(CNT_W));

   always_ff @(posedge clk) begin
      if (reset || clear)
         count <= '0;
      else if (inc && (count != MAX_CNT))
         count <= count + CNT_W'(1);
   end
endmodule

// File: rtl/output_spike_classifier.sv
// Windowed spike counting followed by a sequential lowest-index argmax.
module output_spike_classifier
   import snn_cls_pkg::*;
#(
   parameter int unsigned N_OUT = N_OUT_DEF,
   parameter int unsigned CNT_W = CNT_W_DEF,
   parameter int unsigned WIN_W = WIN_W_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic [WIN_W-1:0]       window_len,
   output logic [N_OUT*CNT_W-1:0] counts_out,
   output logic                   overrun,
   output logic                   busy,
   output_spike_classifier_if.slave bus
);
   localparam int unsigned IDX_W = $clog2(N_OUT);

   state_t           state, state_nxt;
   logic [WIN_W-1:0] win_len, sample_cnt;
   logic [IDX_W-1:0] scan_idx, best_idx, win_idx;
   logic [CNT_W-1:0] best_cnt, win_cnt;
   logic [CNT_W-1:0] cnt [N_OUT];

   logic take_sample, window_done, accept, latch_win, scan_last, drop_sample;

   for (genvar i = 0; i < N_OUT; i++) begin : g_cnt
      spike_sat_counter #(.CNT_W(CNT_W)) u_cnt (
         .clk   (clk),
         .reset (reset),
         .clear (accept),
         .inc   (take_sample & bus.spikes_in[i]),
         .count (cnt[i])
      );
      assign counts_out[i*CNT_W +: CNT_W] = cnt[i];
   end

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (enable)      state_nxt = ST_ACCUM;
         ST_ACCUM:  if (window_done) state_nxt = ST_ARGMAX;
         ST_ARGMAX: if (scan_last)   state_nxt = ST_HOLD;
         ST_HOLD:   if (accept)      state_nxt = enable ? ST_ACCUM : ST_IDLE;
         default:                    state_nxt = ST_IDLE;
      endcase
   end

   // Control strobes and the running argmax candidate (strict > keeps the lowest index on ties).
   always_comb begin
      take_sample = 1'b0;
      window_done = 1'b0;
      accept      = 1'b0;
      latch_win   = 1'b0;
      scan_last   = 1'b0;
      drop_sample = 1'b0;
      win_idx     = best_idx;
      win_cnt     = best_cnt;
      take_sample = (state == ST_ACCUM) && enable && bus.spikes_valid;
      window_done = take_sample && ((sample_cnt + WIN_W'(1)) == win_len);
      accept      = (state == ST_HOLD) && bus.class_ready;
      latch_win   = ((state == ST_IDLE) && enable) || accept;
      scan_last   = (state == ST_ARGMAX) && (scan_idx == IDX_W'(N_OUT - 1));
      drop_sample = bus.spikes_valid && (state != ST_ACCUM);
      if (cnt[scan_idx] > best_cnt) begin
         win_idx = scan_idx;
         win_cnt = cnt[scan_idx];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         win_len         <= '0;
         sample_cnt      <= '0;
         scan_idx        <= '0;
         best_idx        <= '0;
         best_cnt        <= '0;
         bus.class_out   <= '0;
         bus.class_valid <= 1'b0;
         bus.no_spike    <= 1'b0;
         overrun         <= 1'b0;
         busy            <= 1'b0;
      end else begin
         if (latch_win) begin
            win_len    <= (window_len == '0) ? WIN_W'(1) : window_len;
            sample_cnt <= '0;
         end else if (take_sample) begin
            sample_cnt <= sample_cnt + WIN_W'(1);
         end

         if (state == ST_ARGMAX) begin
            scan_idx <= scan_idx + IDX_W'(1);
            best_idx <= win_idx;
            best_cnt <= win_cnt;
         end else begin
            scan_idx <= '0;
            best_idx <= '0;
            best_cnt <= '0;
         end

         if (scan_last) begin
            bus.class_out <= win_idx;
            bus.no_spike  <= (win_cnt == '0);
         end

         if (drop_sample) overrun <= 1'b1;

         bus.class_valid <= (state_nxt == ST_HOLD);
         busy            <= (state_nxt == ST_ARGMAX) || (state_nxt == ST_HOLD);
      end
   end
endmodule

// File: tb/tb_output_spike_classifier.sv
// Self-checking bench: directed scenarios plus randomized back-to-back windows vs a count/argmax model.
module tb_output_spike_classifier;
   import snn_cls_pkg::*;

   localparam int unsigned N  = 8;
   localparam int unsigned CW = 6;
   localparam int unsigned WW = 8;
   localparam int unsigned IW = 3;

   logic            clk = 1'b0;
   logic            reset;
   logic            enable;
   logic [WW-1:0]   window_len;
   logic [N*CW-1:0] counts_out;
   logic            overrun;
   logic            busy;

   output_spike_classifier_if #(.N_OUT(N), .IDX_W(IW)) bus ();

   output_spike_classifier #(.N_OUT(N), .CNT_W(CW), .WIN_W(WW)) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .window_len (window_len),
      .counts_out (counts_out),
      .overrun    (overrun),
      .busy       (busy),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   logic [7:0] stim [$];

   // Model: saturated population count per neuron over the current window.
   function automatic int count_of(input int i);
      int s = 0;
      foreach (stim[k]) s += int'(stim[k][i]);
      return (s > 63) ? 63 : s;
   endfunction

   function automatic logic [N*CW-1:0] exp_counts();
      logic [N*CW-1:0] r = '0;
      for (int i = 0; i < N; i++) r[i*CW +: CW] = CW'(count_of(i));
      return r;
   endfunction

   function automatic int exp_max();
      int m = 0;
      for (int i = 0; i < N; i++) if (count_of(i) > m) m = count_of(i);
      return m;
   endfunction

   function automatic int exp_class();
      for (int i = 0; i < N; i++) if (count_of(i) == exp_max()) return i;
      return 0;
   endfunction

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b1; enable = 1'b0; bus.spikes_valid = 1'b0; bus.class_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic start_accum(input logic [7:0] wl);
      @(negedge clk);
      window_len = wl; enable = 1'b1; bus.spikes_valid = 1'b0;
      @(posedge clk);
   endtask

   task automatic send_sample(input logic [7:0] v);
      @(negedge clk);
      enable = 1'b1; bus.spikes_in = v; bus.spikes_valid = 1'b1;
      @(posedge clk);
   endtask

   // Sends stim[first..] (optionally with idle/disabled gaps) and waits for class_valid.
   task automatic drive_window(input int first, input bit gaps, output int lat,
                               output logic busy0, output logic [N*CW-1:0] cnt0);
      int g;
      for (int k = first; k < stim.size(); k++) begin
         if (gaps) begin
            g = $urandom_range(0, 2);
            repeat (g) begin
               @(negedge clk);
               bus.spikes_valid = 1'b0; enable = 1'($urandom_range(0, 1));
               @(posedge clk);
            end
         end
         send_sample(stim[k]);
      end
      #1 busy0 = busy; cnt0 = counts_out;
      @(negedge clk);
      bus.spikes_valid = 1'b0; bus.spikes_in = '0;
      lat = -1;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         if (bus.class_valid) begin lat = c; break; end
      end
   endtask

   task automatic test_reset();
      #1;
      checks++; if (bus.class_valid !== 1'b0) begin failures++; $display("FAIL reset_class_valid: got %0b expected 0", bus.class_valid); end
      checks++; if (bus.class_out !== 3'd0) begin failures++; $display("FAIL reset_class_out: got %0d expected 0", bus.class_out); end
      checks++; if (bus.no_spike !== 1'b0) begin failures++; $display("FAIL reset_no_spike: got %0b expected 0", bus.no_spike); end
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun: got %0b expected 0", overrun); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b expected 0", busy); end
      checks++; if (counts_out !== '0) begin failures++; $display("FAIL reset_counts: got %h expected 0", counts_out); end
   endtask

   task automatic test_basic();
      int lat; logic b0; logic [N*CW-1:0] c0;
      apply_reset();
      stim = {8'h04, 8'h04, 8'h04, 8'h04};
      bus.class_ready = 1'b1;
      start_accum(8'd4);
      drive_window(0, 1'b0, lat, b0, c0);
      checks++; if (b0 !== 1'b1) begin failures++; $display("FAIL basic_busy_e0: got %0b expected 1", b0); end
      checks++; if (c0 !== exp_counts()) begin failures++; $display("FAIL basic_counts_e0: got %h expected %h", c0, exp_counts()); end
      checks++; if (lat !== 8) begin failures++; $display("FAIL basic_latency: got %0d expected 8", lat); end
      checks++; if (bus.class_out !== 3'd2) begin failures++; $display("FAIL basic_class: got %0d expected 2", bus.class_out); end
      checks++; if (bus.no_spike !== 1'b0) begin failures++; $display("FAIL basic_no_spike: got %0b expected 0", bus.no_spike); end
      @(posedge clk); #1;
      checks++; if (bus.class_valid !== 1'b0) begin failures++; $display("FAIL basic_accept_valid: got %0b expected 0", bus.class_valid); end
      checks++; if (counts_out !== '0) begin failures++; $display("FAIL basic_accept_counts: got %h expected 0", counts_out); end
      bus.class_ready = 1'b0;
   endtask

   task automatic test_tie();
      int lat; logic b0; logic [N*CW-1:0] c0;
      apply_reset();
      stim = {8'h81, 8'h80, 8'h01};
      start_accum(8'd3);
      drive_window(0, 1'b0, lat, b0, c0);
      checks++; if (c0 !== exp_counts()) begin failures++; $display("FAIL tie_counts: got %h expected %h", c0, exp_counts()); end
      checks++; if (lat !== 8) begin failures++; $display("FAIL tie_latency: got %0d expected 8", lat); end
      checks++; if (bus.class_out !== 3'd0) begin failures++; $display("FAIL tie_class: got %0d expected 0", bus.class_out); end
   endtask

   task automatic test_saturation();
      int lat; logic b0; logic [N*CW-1:0] c0;
      apply_reset();
      stim = {};
      for (int k = 0; k < 70; k++) stim.push_back((k < 60) ? 8'h28 : 8'h20);
      start_accum(8'd70);
      drive_window(0, 1'b0, lat, b0, c0);
      checks++; if (c0[5*CW +: CW] !== 6'd63) begin failures++; $display("FAIL sat_n5: got %0d expected 63", c0[5*CW +: CW]); end
      checks++; if (c0[3*CW +: CW] !== 6'd60) begin failures++; $display("FAIL sat_n3: got %0d expected 60", c0[3*CW +: CW]); end
      checks++; if (counts_out !== exp_counts()) begin failures++; $display("FAIL sat_counts_hold: got %h expected %h", counts_out, exp_counts()); end
      checks++; if (lat !== 8) begin failures++; $display("FAIL sat_latency: got %0d expected 8", lat); end
      checks++; if (bus.class_out !== 3'd5) begin failures++; $display("FAIL sat_class: got %0d expected 5", bus.class_out); end
   endtask

   task automatic test_zero_window();
      int lat; logic b0; logic [N*CW-1:0] c0;
      apply_reset();
      stim = {8'h00};
      start_accum(8'd0);
      drive_window(0, 1'b0, lat, b0, c0);
      checks++; if (b0 !== 1'b1) begin failures++; $display("FAIL zero_busy_e0: got %0b expected 1", b0); end
      checks++; if (lat !== 8) begin failures++; $display("FAIL zero_latency: got %0d expected 8", lat); end
      checks++; if (bus.no_spike !== 1'b1) begin failures++; $display("FAIL zero_no_spike: got %0b expected 1", bus.no_spike); end
      checks++; if (bus.class_out !== 3'd0) begin failures++; $display("FAIL zero_class: got %0d expected 0", bus.class_out); end
   endtask

   task automatic test_hold();
      int lat; logic b0; logic [N*CW-1:0] c0;
      logic [N*CW-1:0] ecnt; logic [2:0] ecls;
      apply_reset();
      stim = {8'($urandom) | 8'h10, 8'($urandom)};
      start_accum(8'd2);
      drive_window(0, 1'b0, lat, b0, c0);
      ecnt = exp_counts(); ecls = 3'(exp_class());
      checks++; if (lat !== 8) begin failures++; $display("FAIL hold_latency: got %0d expected 8", lat); end
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL hold_overrun_pre: got %0b expected 0", overrun); end
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         bus.spikes_valid = (k % 5 == 2); bus.spikes_in = 8'hFF;
         @(posedge clk); #1;
         checks++;
         if (bus.class_valid !== 1'b1 || bus.class_out !== ecls || counts_out !== ecnt) begin
            failures++;
            $display("FAIL hold_stable[%0d]: got valid=%0b class=%0d counts=%h expected valid=1 class=%0d counts=%h",
                     k, bus.class_valid, bus.class_out, counts_out, ecls, ecnt);
         end
      end
      @(negedge clk);
      bus.spikes_valid = 1'b0;
      checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL hold_overrun: got %0b expected 1", overrun); end
      bus.class_ready = 1'b1;
      @(posedge clk); #1;
      checks++; if (bus.class_valid !== 1'b0) begin failures++; $display("FAIL hold_accept_valid: got %0b expected 0", bus.class_valid); end
      checks++; if (counts_out !== '0) begin failures++; $display("FAIL hold_accept_counts: got %h expected 0", counts_out); end
      checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL hold_overrun_sticky: got %0b expected 1", overrun); end
      bus.class_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      int lat; logic b0; logic [N*CW-1:0] c0;
      apply_reset();
      start_accum(8'd4);
      send_sample(8'hFF);
      send_sample(8'hFF);
      @(negedge clk);
      bus.spikes_valid = 1'b0; reset = 1'b1;
      @(posedge clk); #1;
      checks++; if (counts_out !== '0) begin failures++; $display("FAIL rmid_counts: got %h expected 0", counts_out); end
      checks++; if (busy !== 1'b0 || bus.class_valid !== 1'b0) begin failures++; $display("FAIL rmid_busy_valid: got %0b/%0b expected 0/0", busy, bus.class_valid); end
      @(negedge clk);
      reset = 1'b0;
      stim = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
      start_accum(8'd4);
      for (int k = 0; k < 3; k++) send_sample(stim[k]);
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_not_closed: got busy=%0b expected 0", busy); end
      drive_window(3, 1'b0, lat, b0, c0);
      checks++; if (b0 !== 1'b1) begin failures++; $display("FAIL rmid_busy_e0: got %0b expected 1", b0); end
      checks++; if (c0 !== exp_counts()) begin failures++; $display("FAIL rmid_counts_e0: got %h expected %h", c0, exp_counts()); end
      checks++; if (bus.class_out !== 3'(exp_class())) begin failures++; $display("FAIL rmid_class: got %0d expected %0d", bus.class_out, exp_class()); end
   endtask

   task automatic test_back_to_back();
      int lat, n, nn; logic b0; logic [N*CW-1:0] c0;
      apply_reset();
      n = $urandom_range(1, 12);
      start_accum(8'(n));
      for (int w = 0; w < 8; w++) begin
         stim = {};
         for (int k = 0; k < n; k++) stim.push_back(8'($urandom) & 8'($urandom) & 8'($urandom));
         drive_window(0, 1'b1, lat, b0, c0);
         checks++; if (lat !== 8) begin failures++; $display("FAIL b2b_latency[%0d]: got %0d expected 8", w, lat); end
         checks++; if (c0 !== exp_counts()) begin failures++; $display("FAIL b2b_counts[%0d]: got %h expected %h", w, c0, exp_counts()); end
         checks++; if (bus.class_out !== 3'(exp_class())) begin failures++; $display("FAIL b2b_class[%0d]: got %0d expected %0d", w, bus.class_out, exp_class()); end
         checks++; if (bus.no_spike !== (exp_max() == 0)) begin failures++; $display("FAIL b2b_no_spike[%0d]: got %0b expected %0b", w, bus.no_spike, exp_max() == 0); end
         nn = $urandom_range(0, 12);
         @(negedge clk);
         window_len = 8'(nn); enable = 1'b1; bus.class_ready = 1'b1;
         @(posedge clk); #1;
         checks++; if (bus.class_valid !== 1'b0 || counts_out !== '0) begin failures++; $display("FAIL b2b_accept[%0d]: got valid=%0b counts=%h expected 0/0", w, bus.class_valid, counts_out); end
         @(negedge clk);
         bus.class_ready = 1'b0;
         n = (nn == 0) ? 1 : nn;
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; enable = 1'b0; window_len = '0;
      bus.spikes_in = '0; bus.spikes_valid = 1'b0; bus.class_ready = 1'b0;
      repeat (2) @(posedge clk);
      test_reset();
      @(negedge clk);
      reset = 1'b0;
      test_basic();
      test_tie();
      test_saturation();
      test_zero_window();
      test_hold();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
